// File: rtl/depth_tester_pkg.sv
// Shared types for the depth_tester Z-test stage: fragment record, FSM states
// and the far-plane depth constant.
package depth_tester_pkg;

    localparam int Z_W     = 15;
    localparam int ADDR_W  = 27;
    localparam int COLOR_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [Z_W-1:0]     depth;
        logic [COLOR_W-1:0] color;
    } frag_t;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [Z_W-1:0] z_max();
        return {Z_W{1'b1}};
    endfunction

endpackage

// File: rtl/depth_tester_ram.sv
// Simple dual-port depth buffer (1 write, 1 read), registered read output so
// synthesis maps it onto block RAM. Contents are not reset.
module depth_ram #(
    parameter int DEPTH = 57600,
    parameter int AW    = 16,
    parameter int DW    = 15
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // read port: old data is returned on a same-address collision
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/depth_tester.sv
// Per-pixel Z-test stage: clear buffer, two-stage read/compare pipeline and an
// output register toward the framebuffer. Optional counters: DEPTH_TESTER_STATS_EN.
module depth_tester
    import depth_tester_pkg::*;
#(
    parameter int Z_WIDTH = Z_W,
    parameter int HRES    = 320,
    parameter int VRES    = 180
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               frame_start_in,
    input  logic               frag_valid_in,
    output logic               frag_ready_out,
    input  logic [26:0]        frag_addr_in,
    input  logic [Z_WIDTH-1:0] frag_depth_in,
    input  logic [15:0]        frag_color_in,
    output logic               pix_valid_out,
    input  logic               pix_ready_in,
    output logic [26:0]        pix_addr_out,
    output logic [Z_WIDTH-1:0] pix_depth_out,
    output logic [15:0]        pix_color_out,
    output logic               pix_strobe_out,
    output logic               busy_out,
    output logic [15:0]        pass_count_out,
    output logic [15:0]        reject_count_out
);

    localparam int                  DEPTH    = HRES * VRES;
    localparam int                  DADDR_W  = $clog2(DEPTH);
    localparam logic [Z_WIDTH-1:0]  Z_MAX    = z_max();
    localparam logic [ADDR_W-1:0]   DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [DADDR_W-1:0]  LAST_PTR = DADDR_W'(DEPTH - 1);

    state_t               state_r, state_s;
    logic [DADDR_W-1:0]   ptr_r, ptr_s;
    logic                 clr_we_s;

    logic                 a_valid_r, a_oob_r;
    frag_t                a_frag_r;
    logic                 b_valid_r, b_oob_r, b_byp_r;
    frag_t                b_frag_r;
    logic [Z_WIDTH-1:0]   b_byp_z_r;
    logic                 pix_valid_r;
    frag_t                pix_frag_r;

    logic [Z_WIDTH-1:0]   rd_data_s, stored_s, wr_data_s;
    logic [DADDR_W-1:0]   rd_addr_s, wr_addr_s;
    logic                 rd_en_s, wr_en_s;
    logic                 out_free_s, b_pass_s, b_stall_s, b_commit_s, b_fire_s;
    logic                 a_adv_s, ready_s, accept_s, byp_hit_s;

    // Stored depth comes from the bypass latch when B overwrote it during the read.
    assign stored_s   = b_byp_r ? b_byp_z_r : rd_data_s;
    assign out_free_s = !pix_valid_r || pix_ready_in;
    assign b_pass_s   = b_valid_r && !b_oob_r && (b_frag_r.depth < stored_s);
    assign b_stall_s  = b_pass_s && !out_free_s;
    assign b_commit_s = b_pass_s && out_free_s;
    assign b_fire_s   = b_valid_r && !b_stall_s;
    assign a_adv_s    = a_valid_r && (!b_valid_r || b_fire_s);
    assign ready_s    = (state_r == ST_RUN) && (!a_valid_r || a_adv_s);
    assign accept_s   = frag_valid_in && ready_s;
    assign byp_hit_s  = b_commit_s && (b_frag_r.addr == a_frag_r.addr);

    // FSM next state and clear pointer
    always_comb begin
        state_s  = state_r;
        ptr_s    = ptr_r;
        clr_we_s = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                clr_we_s = 1'b1;
                if (frame_start_in) begin
                    ptr_s = '0;
                end else if (ptr_r == LAST_PTR) begin
                    state_s = ST_RUN;
                    ptr_s   = '0;
                end else begin
                    ptr_s = ptr_r + DADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (frame_start_in) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!a_valid_r && !b_valid_r) begin
                    state_s = ST_CLEAR;
                    ptr_s   = '0;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_CLEAR;
                ptr_s   = '0;
            end
        endcase
    end

    // RAM port steering; a stalled B re-reads its own address to keep its data
    always_comb begin
        if (b_stall_s) begin
            rd_addr_s = b_frag_r.addr[DADDR_W-1:0];
            rd_en_s   = 1'b1;
        end else begin
            rd_addr_s = a_frag_r.addr[DADDR_W-1:0];
            rd_en_s   = a_valid_r && !a_oob_r;
        end
        if (clr_we_s) begin
            wr_addr_s = ptr_r;
            wr_data_s = Z_MAX;
            wr_en_s   = 1'b1;
        end else begin
            wr_addr_s = b_frag_r.addr[DADDR_W-1:0];
            wr_data_s = b_frag_r.depth;
            wr_en_s   = b_commit_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_CLEAR;
            ptr_r   <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
        end
    end

    // stage A: accept and issue read
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_valid_r <= 1'b0;
            a_oob_r   <= 1'b0;
            a_frag_r  <= '0;
        end else if (accept_s) begin
            a_valid_r <= 1'b1;
            a_oob_r   <= (frag_addr_in >= DEPTH_A);
            a_frag_r  <= '{addr: frag_addr_in, depth: frag_depth_in, color: frag_color_in};
        end else if (a_adv_s) begin
            a_valid_r <= 1'b0;
        end
    end

    // stage B: compare against read data and commit
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            b_valid_r <= 1'b0;
            b_oob_r   <= 1'b0;
            b_byp_r   <= 1'b0;
            b_byp_z_r <= '0;
            b_frag_r  <= '0;
        end else if (a_adv_s) begin
            b_valid_r <= 1'b1;
            b_oob_r   <= a_oob_r;
            b_frag_r  <= a_frag_r;
            b_byp_r   <= byp_hit_s;
            b_byp_z_r <= b_frag_r.depth;
        end else if (b_fire_s) begin
            b_valid_r <= 1'b0;
        end
    end

    // output register toward the framebuffer
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pix_valid_r <= 1'b0;
            pix_frag_r  <= '0;
        end else if (b_commit_s) begin
            pix_valid_r <= 1'b1;
            pix_frag_r  <= b_frag_r;
        end else if (pix_ready_in) begin
            pix_valid_r <= 1'b0;
        end
    end

    depth_ram #(
        .DEPTH (DEPTH),
        .AW    (DADDR_W),
        .DW    (Z_WIDTH)
    ) u_depth_ram (
        .clk     (clk_in),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

`ifdef DEPTH_TESTER_STATS_EN
    logic [15:0] pass_cnt_r, rej_cnt_r;

    // per-frame saturating decision counters; frame start has priority
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pass_cnt_r <= 16'h0000;
            rej_cnt_r  <= 16'h0000;
        end else if (frame_start_in) begin
            pass_cnt_r <= 16'h0000;
            rej_cnt_r  <= 16'h0000;
        end else begin
            if (b_commit_s && (pass_cnt_r != 16'hFFFF)) begin
                pass_cnt_r <= pass_cnt_r + 16'd1;
            end
            if (b_fire_s && !b_pass_s && (rej_cnt_r != 16'hFFFF)) begin
                rej_cnt_r <= rej_cnt_r + 16'd1;
            end
        end
    end

    assign pass_count_out   = pass_cnt_r;
    assign reject_count_out = rej_cnt_r;
`else
    assign pass_count_out   = 16'h0000;
    assign reject_count_out = 16'h0000;
`endif

    assign frag_ready_out = ready_s;
    assign pix_valid_out  = pix_valid_r;
    assign pix_strobe_out = pix_valid_r;
    assign pix_addr_out   = pix_frag_r.addr;
    assign pix_depth_out  = pix_frag_r.depth;
    assign pix_color_out  = pix_frag_r.color;
    assign busy_out       = (state_r != ST_RUN);

endmodule

// File: tb/tb_depth_tester.sv
// Self-checking bench for depth_tester: a per-pixel depth array plus an
// expected-output queue model the Z-test; directed steps then random traffic.
module tb_depth_tester;

    localparam int HRES_T  = 160;
    localparam int VRES_T  = 90;
    localparam int DEPTH_T = HRES_T * VRES_T;
    localparam int DAW     = $clog2(DEPTH_T);
    localparam int ZMAX    = (1 << 15) - 1;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b1;
    logic        frame_start_in = 1'b0;
    logic        frag_valid_in = 1'b0;
    logic        frag_ready_out;
    logic [26:0] frag_addr_in = 27'd0;
    logic [14:0] frag_depth_in = 15'd0;
    logic [15:0] frag_color_in = 16'd0;
    logic        pix_valid_out;
    logic        pix_ready_in = 1'b0;
    logic [26:0] pix_addr_out;
    logic [14:0] pix_depth_out;
    logic [15:0] pix_color_out;
    logic        pix_strobe_out;
    logic        busy_out;
    logic [15:0] pass_count_out;
    logic [15:0] reject_count_out;

    depth_tester #(.Z_WIDTH(15), .HRES(HRES_T), .VRES(VRES_T)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .frame_start_in   (frame_start_in),
        .frag_valid_in    (frag_valid_in),
        .frag_ready_out   (frag_ready_out),
        .frag_addr_in     (frag_addr_in),
        .frag_depth_in    (frag_depth_in),
        .frag_color_in    (frag_color_in),
        .pix_valid_out    (pix_valid_out),
        .pix_ready_in     (pix_ready_in),
        .pix_addr_out     (pix_addr_out),
        .pix_depth_out    (pix_depth_out),
        .pix_color_out    (pix_color_out),
        .pix_strobe_out   (pix_strobe_out),
        .busy_out         (busy_out),
        .pass_count_out   (pass_count_out),
        .reject_count_out (reject_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int addr;
        int z;
        int color;
        int due;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   zbuf [DEPTH_T];
    int   mpass = 0;
    int   mrej = 0;
    bit   rand_ready = 1'b0;
    exp_t exp_q [$];
    exp_t mon_e;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Z-test reference: a fragment passes when strictly closer than the pixel's stored depth.
    task automatic model(input int addr, input int z, input int color, input int due);
        if (addr < DEPTH_T && z < zbuf[addr]) begin
            zbuf[addr] = z;
            exp_q.push_back('{addr, z, color, due});
            mpass++;
        end else begin
            mrej++;
        end
    endtask

    task automatic send(input int addr, input int z, input int color, input bit tchk);
        bit acc = 1'b0;
        frag_valid_in = 1'b1;
        frag_addr_in  = 27'(addr);
        frag_depth_in = 15'(z);
        frag_color_in = 16'(color);
        for (int w = 0; w < 400; w++) begin
            @(negedge clk_in);
            acc = frag_ready_out;
            @(posedge clk_in);
            #1;
            if (rand_ready) pix_ready_in = 1'($urandom_range(0, 1));
            if (acc) break;
        end
        chk("accept", 64'(acc), 64'd1);
        if (acc) model(addr, z, color, tchk ? cyc + 2 : -1);
    endtask

    task automatic idle(input int n);
        frag_valid_in = 1'b0;
        repeat (n) begin
            @(posedge clk_in);
            #1;
            if (rand_ready) pix_ready_in = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_drain();
        rand_ready   = 1'b0;
        pix_ready_in = 1'b1;
        frag_valid_in = 1'b0;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) idle(1);
        idle(4);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_stats();
`ifdef DEPTH_TESTER_STATS_EN
        chk("pass_count", 64'(pass_count_out), 64'(mpass));
        chk("reject_count", 64'(reject_count_out), 64'(mrej));
`else
        chk("pass_count", 64'(pass_count_out), 64'd0);
        chk("reject_count", 64'(reject_count_out), 64'd0);
`endif
    endtask

    // Output monitor: every handshake must match the head of the expected queue.
    always @(negedge clk_in) begin
        if (rst_n_in && pix_valid_out && pix_ready_in) begin
            chk("unexpected_output", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("pix_data", {pix_addr_out, pix_depth_out, pix_color_out},
                    64'({27'(mon_e.addr), 15'(mon_e.z), 16'(mon_e.color)}));
                chk("pix_strobe", 64'(pix_strobe_out), 64'd1);
                if (mon_e.due >= 0) chk("latency", 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, bad, got, a;
        foreach (zbuf[i]) zbuf[i] = ZMAX;
        #2 rst_n_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_ready", 64'(frag_ready_out), 64'd0);
        chk("rst_busy", 64'(busy_out), 64'd1);
        chk("rst_pix_valid", 64'(pix_valid_out), 64'd0);
        chk("rst_pix_data", {pix_addr_out, pix_depth_out, pix_color_out}, 64'd0);
        chk_stats();

        // clear length with a fragment held valid throughout
        frag_valid_in = 1'b1;
        frag_addr_in  = 27'(DEPTH_T);
        rst_n_in = 1'b1;
        n = 0; bad = 0; got = 0;
        for (int i = 0; i < DEPTH_T + 50; i++) begin
            @(posedge clk_in);
            #1;
            n++;
            if (frag_ready_out) begin
                got = 1;
                break;
            end
            if (!busy_out) bad++;
        end
        frag_valid_in = 1'b0;
        chk("clear_done", 64'(got), 64'd1);
        chk("clear_cycles", 64'(n), 64'(DEPTH_T));
        chk("clear_busy", 64'(bad), 64'd0);
        chk("run_busy", 64'(busy_out), 64'd0);

        // back-to-back same address, timing checked
        pix_ready_in = 1'b1;
        send(5, 100, 16'hA001, 1'b1);
        send(5, 200, 16'hA002, 1'b1);
        send(5, 50, 16'hA003, 1'b1);
        wait_drain();

        // tie rejects
        send(7, 300, 16'hB001, 1'b1);
        send(7, 300, 16'hB002, 1'b1);
        wait_drain();
        chk_stats();

        // out-of-range indices, one aliasing address 9 in the low bits
        send(DEPTH_T, 7, 16'hC001, 1'b1);
        send((1 << DAW) + 9, 5, 16'hC002, 1'b1);
        send(9, 1000, 16'hC003, 1'b1);
        wait_drain();

        // output backpressure with three passing fragments
        pix_ready_in = 1'b0;
        send(10, 20, 16'hD001, 1'b0);
        send(11, 21, 16'hD002, 1'b0);
        send(12, 22, 16'hD003, 1'b0);
        idle(10);
        chk("stall_ready", 64'(frag_ready_out), 64'd0);
        chk("stall_pix_valid", 64'(pix_valid_out), 64'd1);
        chk("stall_pix_addr", 64'(pix_addr_out), 64'd10);
        wait_drain();
        chk_stats();

        // random traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 19) == 0) ? DEPTH_T + int'($urandom_range(0, 100))
                                             : int'($urandom_range(0, 15));
            send(a, int'($urandom_range(0, 255)), int'($urandom_range(0, 65535)), 1'b0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        wait_drain();
        chk_stats();

        // frame start mid-stream
        send(5, 150, 16'hE001, 1'b0);
        for (int i = 0; i < 4; i++)
            send(20 + i, int'($urandom_range(0, 255)), int'($urandom_range(0, 65535)), 1'b0);
        frag_valid_in  = 1'b0;
        frame_start_in = 1'b1;
        @(posedge clk_in);
        #1;
        frame_start_in = 1'b0;
        foreach (zbuf[i]) zbuf[i] = ZMAX;
        chk("drain_busy", 64'(busy_out), 64'd1);
        chk("drain_ready", 64'(frag_ready_out), 64'd0);
        got = 0;
        for (int i = 0; i < DEPTH_T + 200; i++) begin
            @(posedge clk_in);
            #1;
            if (!busy_out) begin
                got = 1;
                break;
            end
        end
        chk("reclear_done", 64'(got), 64'd1);
        chk("reclear_ready", 64'(frag_ready_out), 64'd1);
        send(5, 150, 16'hE002, 1'b1);
        wait_drain();

        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
